ntt_bank_addr_gen: RTL



---
 rtl/ntt_pkg.sv | 31 +++
 rtl/ntt_bank_addr_gen_if.sv | 46 ++++
 rtl/bit_scatter.sv | 30 +++
 rtl/ntt_bank_addr_gen.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared types and helpers for the NTT bank/address generator.
package ntt_pkg;

    // Widest coefficient index the bank fold accepts.
    localparam int unsigned IDX_W_MAX = 32;

    // Coefficient index width for a given in-bank address width.
    function automatic int unsigned log_n_of(input int unsigned addr_width);
        return addr_width + 2;
    endfunction

    typedef logic [1:0] bank_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bank of a coefficient index: XOR of all its 2-bit digits.
    function automatic bank_t bank_of(input logic [IDX_W_MAX-1:0] idx);
        bank_t acc;
        acc = '0;
        for (int unsigned k = 0; k < IDX_W_MAX / 2; k++) begin
            acc = acc ^ idx[2*k +: 2];
        end
        return acc;
    endfunction

endpackage

// File: rtl/ntt_bank_addr_gen_if.sv
// Control and beat bus between the NTT address generator and its consumers.
interface ntt_bank_addr_gen_if #(
    parameter int unsigned ADDR_WIDTH = 8
) ();
    import ntt_pkg::*;

    localparam int unsigned LOG_N = log_n_of(ADDR_WIDTH);
    localparam int unsigned SW    = $clog2(LOG_N);

    logic                  start;
    logic                  stall;
    logic                  busy;
    logic                  valid;
    logic [ADDR_WIDTH-1:0] b0;
    logic [ADDR_WIDTH-1:0] b1;
    logic [ADDR_WIDTH-1:0] b2;
    logic [ADDR_WIDTH-1:0] b3;
    bank_t                 sel_a_0;
    bank_t                 sel_a_1;
    bank_t                 sel_a_2;
    bank_t                 sel_a_3;
    bank_t                 sel_d_0;
    bank_t                 sel_d_1;
    bank_t                 sel_d_2;
    bank_t                 sel_d_3;
    logic [SW-1:0]         stage;
    logic                  last;
    logic                  done;

    modport master (
        input  start, stall,
        output busy, valid, b0, b1, b2, b3,
               sel_a_0, sel_a_1, sel_a_2, sel_a_3,
               sel_d_0, sel_d_1, sel_d_2, sel_d_3,
               stage, last, done
    );

    modport slave (
        output start, stall,
        input  busy, valid, b0, b1, b2, b3,
               sel_a_0, sel_a_1, sel_a_2, sel_a_3,
               sel_d_0, sel_d_1, sel_d_2, sel_d_3,
               stage, last, done
    );

endinterface

// File: rtl/bit_scatter.sv
// Spreads the beat counter over every index bit except the stage bit and its companion.
module bit_scatter
    import ntt_pkg::*;
#(
    parameter  int unsigned ADDR_WIDTH = 8,
    localparam int unsigned LOG_N      = log_n_of(ADDR_WIDTH),
    localparam int unsigned SW         = $clog2(LOG_N)
) (
    input  logic [ADDR_WIDTH-1:0] cnt,
    input  logic [SW-1:0]         stage,
    output logic [LOG_N-1:0]      base_c
);

    logic [SW-1:0]    mate;
    logic [SW-1:0]    lo;
    logic [SW-1:0]    hi;
    logic [LOG_N-1:0] wide;
    logic [LOG_N-1:0] step;

    // Open a zero hole at the lower excluded position, then at the higher one.
    always_comb begin
        mate   = stage[0] ? '0 : SW'(1);
        lo     = (mate < stage) ? mate : stage;
        hi     = (mate < stage) ? stage : mate;
        wide   = LOG_N'(cnt);
        step   = (((wide >> lo) << 1) << lo) | (wide & ~({LOG_N{1'b1}} << lo));
        base_c = (((step >> hi) << 1) << hi) | (step & ~({LOG_N{1'b1}} << hi));
    end

endmodule

// File: rtl/ntt_bank_addr_gen.sv
// Per-beat lane addresses and bank steering for a conflict-free radix-2 NTT schedule.
module ntt_bank_addr_gen
    import ntt_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    ntt_bank_addr_gen_if.master bus
);

    localparam int unsigned LOG_N = log_n_of(ADDR_WIDTH);
    localparam int unsigned SW    = $clog2(LOG_N);
    localparam int unsigned LANES = 4;

    typedef logic [LOG_N-1:0] idx_t;

    state_t                state;
    state_t                state_nx;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_nx;
    logic [SW-1:0]         stg;
    logic [SW-1:0]         stg_nx;
    logic                  busy_q;
    logic                  busy_nx;
    logic                  done_q;
    logic                  done_nx;
    logic                  issue_c;
    logic                  at_end_c;

    idx_t                  base_c;
    idx_t                  s_mask_c;
    idx_t                  p_mask_c;
    idx_t                  lane_c [LANES];

    idx_t                  lane_q [LANES];
    logic [SW-1:0]         stg1_q;
    logic                  last1_q;
    logic                  valid1_q;

    logic [ADDR_WIDTH-1:0] addr_c  [LANES];
    bank_t                 bank_c  [LANES];
    bank_t                 sel_a_c [LANES];

    logic                  valid_q;
    logic                  last_q;
    logic [SW-1:0]         stage_q;
    logic [ADDR_WIDTH-1:0] addr_q  [LANES];
    bank_t                 sel_d_q [LANES];
    bank_t                 sel_a_q [LANES];

    assign at_end_c = (stg == SW'(LOG_N - 1)) && (cnt == '1);

    // Next state, beat counters and status flags; a stall holds everything.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        stg_nx   = stg;
        busy_nx  = busy_q;
        done_nx  = done_q;
        issue_c  = 1'b0;
        if (!bus.stall) begin
            case (state)
                IDLE: begin
                    busy_nx = 1'b0;
                    done_nx = 1'b0;
                    if (bus.start) begin
                        state_nx = RUN;
                        cnt_nx   = '0;
                        stg_nx   = '0;
                        busy_nx  = 1'b1;
                    end
                end
                RUN: begin
                    issue_c = 1'b1;
                    busy_nx = 1'b1;
                    cnt_nx  = cnt + ADDR_WIDTH'(1);
                    if (cnt == '1) begin
                        stg_nx = stg + SW'(1);
                    end
                    if (at_end_c) begin
                        state_nx = FLUSH;
                        stg_nx   = '0;
                    end
                end
                FLUSH: begin
                    if (valid_q && last_q) begin
                        state_nx = DONE;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                    end
                end
                DONE: begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b0;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // FSM state, counters and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            stg    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            stg    <= stg_nx;
            busy_q <= busy_nx;
            done_q <= done_nx;
        end
    end

    bit_scatter #(.ADDR_WIDTH(ADDR_WIDTH)) u_scatter (
        .cnt    (cnt),
        .stage  (stg),
        .base_c (base_c)
    );

    // Four lane indices of the two butterflies built from the base index.
    always_comb begin
        s_mask_c  = idx_t'(1) << stg;
        p_mask_c  = stg[0] ? idx_t'(1) : idx_t'(2);
        lane_c[0] = base_c;
        lane_c[1] = base_c | s_mask_c;
        lane_c[2] = base_c | p_mask_c;
        lane_c[3] = base_c | s_mask_c | p_mask_c;
    end

    // P1: lane indices with stage/last tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q   <= '{default: '0};
            stg1_q   <= '0;
            last1_q  <= 1'b0;
            valid1_q <= 1'b0;
        end else if (!bus.stall) begin
            valid1_q <= issue_c;
            if (issue_c) begin
                lane_q  <= lane_c;
                stg1_q  <= stg;
                last1_q <= at_end_c;
            end
        end
    end

    // Split indices into address and bank, and invert the lane-to-bank map.
    always_comb begin
        for (int unsigned j = 0; j < LANES; j++) begin
            addr_c[j] = lane_q[j][LOG_N-1:2];
            bank_c[j] = bank_of(IDX_W_MAX'(lane_q[j]));
        end
        sel_a_c = '{default: '0};
        for (int unsigned j = 0; j < LANES; j++) begin
            sel_a_c[bank_c[j]] = bank_t'(j);
        end
    end

    // P2: output registers; data holds while no beat is present.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            stage_q <= '0;
            addr_q  <= '{default: '0};
            sel_d_q <= '{2'd0, 2'd1, 2'd2, 2'd3};
            sel_a_q <= '{2'd0, 2'd1, 2'd2, 2'd3};
        end else if (!bus.stall) begin
            valid_q <= valid1_q;
            last_q  <= valid1_q & last1_q;
            if (valid1_q) begin
                stage_q <= stg1_q;
                addr_q  <= addr_c;
                sel_d_q <= bank_c;
                sel_a_q <= sel_a_c;
            end
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.valid   = valid_q;
    assign bus.last    = last_q;
    assign bus.stage   = stage_q;
    assign bus.b0      = addr_q[0];
    assign bus.b1      = addr_q[1];
    assign bus.b2      = addr_q[2];
    assign bus.b3      = addr_q[3];
    assign bus.sel_d_0 = sel_d_q[0];
    assign bus.sel_d_1 = sel_d_q[1];
    assign bus.sel_d_2 = sel_d_q[2];
    assign bus.sel_d_3 = sel_d_q[3];
    assign bus.sel_a_0 = sel_a_q[0];
    assign bus.sel_a_1 = sel_a_q[1];
    assign bus.sel_a_2 = sel_a_q[2];
    assign bus.sel_a_3 = sel_a_q[3];

endmodule
